// File: rtl/lsu_pkg.sv
// Shared load/store unit types: funct3 encodings, FSM states, error causes.
package lsu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned WEB_W   = 4;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = 2'b11;

    // Loads never write: all active-low byte enables deasserted.
    localparam logic [WEB_W-1:0] DM_WEB_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Context of the load in flight, captured at acceptance.
    typedef struct packed {
        logic [F3_W-1:0]  funct3;
        logic [OFF_W-1:0] off;
        logic [REG_W-1:0] rd;
    } load_ctx_t;

    function automatic logic is_legal_load(input logic [F3_W-1:0] f3);
        logic legal;
        legal = 1'b0;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Only a halfword straddling the word boundary is misaligned; LW ignores the offset.
    function automatic logic is_misaligned(input logic [F3_W-1:0] f3, input logic [OFF_W-1:0] off);
        return ((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'b11);
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a memory word and extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]  rdata,
    input  logic [F3_W-1:0]  funct3,
    input  logic [OFF_W-1:0] off,
    output logic [XLEN-1:0]  data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte and halfword lane selection by address offset.
    always_comb begin : lane_select
        lane_b = rdata[7:0];
        lane_h = rdata[15:0];
        case (off)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        case (off)
            2'b00:   lane_h = rdata[15:0];
            2'b01:   lane_h = rdata[23:8];
            default: lane_h = rdata[31:16];
        endcase
    end

    // Sign or zero extension according to the load type.
    always_comb begin : extend
        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
            F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_access_ctrl.sv
// MEM-stage load controller: issues word reads over req/gnt/rvalid, stalls
// the pipeline while in flight, and returns extended data or an error pulse.
module load_access_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    input  logic [F3_W-1:0]    ld_funct3,
    input  logic [XLEN-1:0]    ld_addr,
    input  logic [REG_W-1:0]   ld_rd,
    input  logic               flush,
    output logic               ld_stall,
    output logic               ld_done,
    output logic [XLEN-1:0]    ld_data,
    output logic [REG_W-1:0]   ld_rd_out,
    output logic               ld_err,
    output logic [CAUSE_W-1:0] ld_err_cause,
    output logic               dm_req,
    output logic [XLEN-1:0]    dm_addr,
    output logic [WEB_W-1:0]   dm_web,
    input  logic               dm_gnt,
    input  logic               dm_rvalid,
    input  logic [XLEN-1:0]    dm_rdata
);

    // Counter holds 0..TIMEOUT; it may step once past the last check when rvalid wins.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    load_ctx_t         ctx_q, ctx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              take;
    logic              legal;
    logic              misal;
    logic              to_hit;
    logic [XLEN-1:0]   aligned;

    logic               done_d;
    logic               err_d;
    logic [CAUSE_W-1:0] cause_d;
    logic [REG_W-1:0]   rd_out_d;
    logic [XLEN-1:0]    data_d;
    logic               req_d;
    logic [XLEN-1:0]    addr_d;

    assign take   = ld_valid & ~flush;
    assign legal  = is_legal_load(ld_funct3);
    assign misal  = is_misaligned(ld_funct3, ld_addr[1:0]);
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign dm_web = DM_WEB_NONE;

    load_align u_align (
        .rdata  (dm_rdata),
        .funct3 (ctx_q.funct3),
        .off    (ctx_q.off),
        .data   (aligned)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush beats timeout, timeout beats gnt, rvalid beats timeout.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take && legal && !misal) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = (dm_gnt && !to_hit) ? ST_DRAIN : ST_IDLE;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                end else if (dm_gnt) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush) begin
                    state_d = (dm_rvalid || to_hit) ? ST_IDLE : ST_DRAIN;
                end else if (dm_rvalid || to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (dm_rvalid || to_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, plus the combinational stall.
    always_comb begin : output_logic
        ld_stall = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cause_d  = ld_err_cause;
        rd_out_d = ld_rd_out;
        data_d   = ld_data;
        req_d    = 1'b0;
        addr_d   = dm_addr;
        ctx_d    = ctx_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    ld_stall     = 1'b1;
                    ctx_d.funct3 = ld_funct3;
                    ctx_d.off    = ld_addr[1:0];
                    ctx_d.rd     = ld_rd;
                    if (!legal) begin
                        err_d    = 1'b1;
                        cause_d  = CAUSE_ILLEGAL;
                        rd_out_d = ld_rd;
                    end else if (misal) begin
                        err_d    = 1'b1;
                        cause_d  = CAUSE_MISALIGN;
                        rd_out_d = ld_rd;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = {ld_addr[XLEN-1:2], 2'b00};
                        cnt_d  = '0;
                    end
                end
            end
            ST_REQ: begin
                ld_stall = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (flush) begin
                    req_d = 1'b0;
                end else if (to_hit) begin
                    err_d    = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                    rd_out_d = ctx_q.rd;
                end else begin
                    req_d = ~dm_gnt;
                end
            end
            ST_RESP: begin
                ld_stall = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (!flush && dm_rvalid) begin
                    done_d   = 1'b1;
                    data_d   = aligned;
                    rd_out_d = ctx_q.rd;
                end else if (!flush && to_hit) begin
                    err_d    = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                    rd_out_d = ctx_q.rd;
                end
            end
            ST_DRAIN: begin
                ld_stall = ld_valid;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Registered outputs and in-flight context.
    always_ff @(posedge clk or negedge rst_n) begin : out_reg
        if (!rst_n) begin
            ld_done      <= 1'b0;
            ld_err       <= 1'b0;
            ld_err_cause <= CAUSE_NONE;
            ld_rd_out    <= '0;
            ld_data      <= '0;
            dm_req       <= 1'b0;
            dm_addr      <= '0;
            ctx_q        <= '0;
            cnt_q        <= '0;
        end else begin
            ld_done      <= done_d;
            ld_err       <= err_d;
            ld_err_cause <= cause_d;
            ld_rd_out    <= rd_out_d;
            ld_data      <= data_d;
            dm_req       <= req_d;
            dm_addr      <= addr_d;
            ctx_q        <= ctx_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/load_access_ctrl.md
Name: load_access_ctrl

Overview:
- Load-side counterpart of the store byte-enable logic in the MEM stage.
- Accepts a load from the pipeline, issues a word-aligned read to data memory over a req/gnt/rvalid handshake, and stalls the pipeline while the access is in flight.
- Extracts the addressed byte or halfword from the returned word and sign- or zero-extends it for writeback.
- Handles flush, misalignment, illegal funct3 and bus timeout.

Parameters:
TIMEOUT, 16, cycles allowed in REQ+RESP before a bus error; 0 disables the timeout.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  load request from MEM stage
ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ld_addr  in  32  byte address
ld_rd  in  5  destination register
flush  in  1  kill current/incoming load
ld_stall  out  1  hold pipeline
ld_done  out  1  one-cycle result-valid pulse
ld_data  out  32  extended load result
ld_rd_out  out  5  destination register, valid with ld_done/ld_err
ld_err  out  1  one-cycle error pulse
ld_err_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
dm_req  out  1  read request, registered
dm_addr  out  32  {addr[31:2],2'b00}
dm_web  out  4  active-low byte write enables; constant 4'b1111
dm_gnt  in  1  request accepted
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read data

Behaviour:
- Reset: async on rst_n low. State IDLE; all registered outputs 0; dm_web 4'b1111; timeout counter 0.
- States: IDLE, REQ, RESP, DRAIN.
- IDLE, ld_valid & !flush:
  - Latch funct3, addr[1:0], rd; ld_stall=1 combinationally in this cycle.
  - Illegal funct3 (011, 110, 111): next cycle ld_err=1, cause 10; no dm_req; stay IDLE.
  - LH/LHU with addr[1:0]==11: next cycle ld_err=1, cause 01; no dm_req; stay IDLE.
  - LW ignores addr[1:0].
  - Otherwise go to REQ: dm_req=1 and dm_addr valid from the next cycle.
- IDLE, ld_valid & flush: ignored.
- REQ: hold dm_req and dm_addr until dm_gnt. On dm_gnt, drop dm_req and go to RESP. dm_rvalid in the gnt cycle is not sampled.
- RESP: on dm_rvalid, register the extracted data. Next cycle: ld_done=1, ld_data valid, ld_rd_out=rd, state IDLE.
- ld_stall:
  - 1 in REQ, RESP and the acceptance cycle; 0 in the ld_done cycle.
  - In DRAIN: ld_stall = ld_valid.
- A new ld_valid is accepted in the ld_done cycle (back-to-back loads).
- Minimum latency, accept to ld_done: 3 cycles (gnt in first REQ cycle, rvalid in first RESP cycle).
- Extraction, with off=addr[1:0]:
  - Byte = rdata[8*off+7 : 8*off].
  - Halfword off 00 -> [15:0], 01 -> [23:8], 10 -> [31:16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes rdata.
- Flush:
  - REQ without gnt: drop dm_req, go to IDLE, no ld_done.
  - REQ with gnt in the same cycle: go to DRAIN.
  - RESP with dm_rvalid in the same cycle: go to IDLE, discard data.
  - RESP without rvalid: go to DRAIN.
  - DRAIN: wait for dm_rvalid, then IDLE, no ld_done/ld_err. Flush in DRAIN has no effect.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP/DRAIN.
  - At TIMEOUT: drop dm_req and go to IDLE. Outside DRAIN, also pulse ld_err cause 11 with ld_rd_out.
  - A late dm_rvalid in IDLE is ignored.
- ld_done and ld_err are never high together. ld_data holds its last value between pulses.
- Reset mid-operation: immediate IDLE, no pulses.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 load constants
  - state enum (IDLE/REQ/RESP/DRAIN)
  - err-cause constants
  - DM_WEB_NONE = 4'b1111
- One combinational sub-module, load_align (rdata, funct3, off -> 32-bit extended data), instantiated once. It is reusable by a future unaligned-access path.

Test Plan:
- dm_rdata=0x8899AABB, 0-wait memory: LB off01 -> 0xFFFFFFAA; LBU off01 -> 0x000000AA; LH off01 -> 0xFFFF99AA; LHU off10 -> 0x00008899; LW off11 -> 0x8899AABB. Each ld_done exactly 3 cycles after accept.
- LH addr 0x00001003 -> no dm_req, ld_err=1 cause 01 the next cycle. funct3=011 -> cause 10. ld_stall high only in the accept cycle.
- gnt delayed 4 cycles, rvalid delayed 2 more -> dm_req high exactly 4 cycles, dm_addr 0x00001000, ld_stall high until the ld_done cycle. Back-to-back second load accepted in the ld_done cycle.
- Flush in RESP before rvalid -> DRAIN; rvalid 2 cycles later -> IDLE with no ld_done. Flush in REQ with no gnt -> dm_req drops next cycle.
- TIMEOUT=16, gnt never asserted -> ld_err cause 11 and dm_req low 16 cycles after REQ entry. A later stray rvalid is ignored.
- rst_n low during RESP -> all outputs 0 asynchronously. After release, state is IDLE and a new LW completes normally.
